sprite_frame_buffer: RTL and testbench
======================================

# sprite_frame_buffer

Parametrised successor to the fixed five-sprite wiring between game logic and renderer. Holds position and direction for N sprites in a double buffer, so game logic writes a back copy while the renderer reads a stable front copy. The back copy becomes visible atomically at a frame boundary. Also generates the game-logic tick as a single-cycle enable derived from frame starts, replacing the divided clock so the whole path runs on one clock.

## Interface
- N_SPRITES, 5: sprite count; index 0 is Pac-Man, 1..N-1 are ghosts
- X_W, 11: x position width
- Y_W, 10: y position width
- DIR_W, 4: direction field width
- FRAMES_PER_TICK, 4: frame starts per game tick (≥1)
- FRAME_W, 16: frame counter width
- IDX_W, $clog2(N_SPRITES) (min 1): write index width

Ports:
- clk  in  1  pixel clock; one clock only
- rst  in  1  reset, asynchronous and active-high
- frame_start  in  1  one-cycle pulse at the first blanking line of each frame
- pause  in  1  freezes the tick divider
- wr_en  in  1  write one back-buffer entry
- wr_idx  in  IDX_W  sprite index
- wr_x / wr_y / wr_dir  in  X_W / Y_W / DIR_W  entry data
- commit  in  1  back buffer complete; request swap
- tick  out  1  one-cycle game-logic enable
- pending  out  1  commit accepted, swap not yet done
- overrun  out  1  sticky: write attempted while pending
- frame_cnt  out  FRAME_W  frame starts since reset, wraps
- front_x / front_y / front_dir  out  N_SPRITES*X_W / *Y_W / *DIR_W  flattened front buffer; sprite i at slice [i*W +: W]

## Operation
- Reset:
  - all back and front entries are 0; tick=0, pending=0, overrun=0, frame_cnt=0; divider count=0.
- Write:
  - If wr_en && !pending && wr_idx<N_SPRITES, the back entry is updated at the clock edge.
  - If wr_idx≥N_SPRITES, the write is silently ignored; no flag is set.
  - If wr_en && pending, the write is dropped and overrun is set to 1; overrun stays 1 until reset.
- Commit:
  - commit sets pending=1. Commit while pending is already 1 has no further effect.
- Swap:
  - On frame_start with pending=1, or with commit=1 in the same cycle, all front entries are loaded from the back entries and pending is cleared.
  - If a write is accepted in the swap cycle, the front buffer takes the pre-write back value; the write lands in the back buffer only.
  - Back entries persist after a swap; sprites that are not rewritten keep their position.
- Tick divider:
  - On frame_start with pause=0: if count==FRAMES_PER_TICK-1, count←0 and tick=1 in the next cycle; otherwise count increments.
  - With pause=1, count holds and no tick is issued. Swaps and frame_cnt are unaffected by pause.
- frame_cnt increments on every frame_start and wraps modulo 2^FRAME_W.

## Timing
- All outputs are registered.
- Front buffer updates at the frame_start edge; it is visible the cycle after the pulse.
- tick is high exactly one cycle, the cycle after the qualifying frame_start.
- First tick comes after the FRAMES_PER_TICK-th frame_start following reset. With FRAMES_PER_TICK=1, tick follows every unpaused frame_start.
- Write-to-front latency: at least 1 cycle after commit, at most one frame.
- Reset asserted mid-frame clears everything immediately (asynchronous). An in-flight pending commit is lost.
- frame_start pulses closer together than 2 cycles are out of spec.

## Structure
- `game_pkg`: X_W/Y_W/DIR_W defaults, one-hot direction encoding (DIR_UP=4'b0001, DOWN=0010, LEFT=0100, RIGHT=1000), sprite index constants (PACMAN=0, BLINKY=1, PINKY=2, INKY=3, CLYDE=4).
- Sub-module `frame_tick_div`: frame_start/pause in, tick out; parametrised by FRAMES_PER_TICK.
- Buffers are generate-loop register arrays; no RAM inference.

## Test plan
- Reset then idle → all front slices 0; tick, pending and overrun 0; frame_cnt 0.
- Write idx2 x=100 y=50 dir=0100, commit, pulse frame_start → front_x[2]=100, front_y[2]=50, front_dir[2]=0100 one cycle after the pulse; pending back to 0.
- Commit, then write idx1 x=7 before frame_start → write dropped, overrun=1 and stays 1. After the swap, front_x[1] holds its old value.
- FRAMES_PER_TICK=4, 10 frame_starts, pause held across frames 5–6 → exactly 2 ticks, each one cycle after the 4th and 10th frame_start; frame_cnt=10.
- commit coincident with frame_start, plus a write to idx0 x=9 in the same cycle → swap occurs and front_x[0] has the old value; the next commit+frame_start shows 9.
- wr_idx=N_SPRITES with wr_en → no entry changes, overrun stays 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants: default field widths, direction encoding and sprite indices.
package game_pkg;

    localparam int GAME_N_SPRITES       = 5;
    localparam int GAME_X_W             = 11;
    localparam int GAME_Y_W             = 10;
    localparam int GAME_DIR_W           = 4;
    localparam int GAME_FRAMES_PER_TICK = 4;
    localparam int GAME_FRAME_W         = 16;

    typedef enum logic [3:0] {
        DIR_NONE  = 4'b0000,
        DIR_UP    = 4'b0001,
        DIR_DOWN  = 4'b0010,
        DIR_LEFT  = 4'b0100,
        DIR_RIGHT = 4'b1000
    } dir_e;

    localparam int PACMAN = 0;
    localparam int BLINKY = 1;
    localparam int PINKY  = 2;
    localparam int INKY   = 3;
    localparam int CLYDE  = 4;

    // Index width that stays at least one bit even for a single entry.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_frame_buffer_if.sv
// Game-logic side of the sprite frame buffer: write port, commit/frame control and status.
interface sprite_frame_buffer_if
    import game_pkg::*;
#(
    parameter int IDX_W = idx_width(GAME_N_SPRITES),
    parameter int X_W   = GAME_X_W,
    parameter int Y_W   = GAME_Y_W,
    parameter int DIR_W = GAME_DIR_W
);
    logic             frame_start;
    logic             pause;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [X_W-1:0]   wr_x;
    logic [Y_W-1:0]   wr_y;
    logic [DIR_W-1:0] wr_dir;
    logic             commit;
    logic             tick;
    logic             pending;
    logic             overrun;

    modport master (
        output frame_start, pause, wr_en, wr_idx, wr_x, wr_y, wr_dir, commit,
        input  tick, pending, overrun
    );

    modport slave (
        input  frame_start, pause, wr_en, wr_idx, wr_x, wr_y, wr_dir, commit,
        output tick, pending, overrun
    );
endinterface

// File: rtl/frame_tick_div.sv
// Divides frame_start pulses into a single-cycle game-logic tick, frozen while paused.
module frame_tick_div
    import game_pkg::*;
#(
    parameter int FRAMES_PER_TICK = GAME_FRAMES_PER_TICK
) (
    input  logic clk,
    input  logic rst,
    input  logic i_frame_start,
    input  logic i_pause,
    output logic o_tick
);
    localparam int               CNT_W = idx_width(FRAMES_PER_TICK);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAMES_PER_TICK - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_tick;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (i_frame_start && !i_pause) begin
                if (r_count == LAST) begin
                    r_count <= '0;
                    r_tick  <= 1'b1;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
        end
    end

    assign o_tick = r_tick;
endmodule

// File: rtl/sprite_frame_buffer.sv
// Double-buffered sprite state: game logic fills the back copy, the renderer reads the
// front copy, which is reloaded atomically at a frame boundary after a commit.
module sprite_frame_buffer
    import game_pkg::*;
#(
    parameter int N_SPRITES       = GAME_N_SPRITES,
    parameter int X_W             = GAME_X_W,
    parameter int Y_W             = GAME_Y_W,
    parameter int DIR_W           = GAME_DIR_W,
    parameter int FRAMES_PER_TICK = GAME_FRAMES_PER_TICK,
    parameter int FRAME_W         = GAME_FRAME_W,
    parameter int IDX_W           = idx_width(N_SPRITES)
) (
    input  logic                       clk,
    input  logic                       rst,
    sprite_frame_buffer_if.slave       bus,
    output logic [FRAME_W-1:0]         o_frame_cnt,
    output logic [N_SPRITES*X_W-1:0]   o_front_x,
    output logic [N_SPRITES*Y_W-1:0]   o_front_y,
    output logic [N_SPRITES*DIR_W-1:0] o_front_dir
);
    localparam logic [IDX_W:0] IDX_LIMIT = (IDX_W + 1)'(N_SPRITES);

    logic               r_pending;
    logic               r_overrun;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               w_tick;
    logic               w_swap;
    logic               w_wr_ok;

    // A commit arriving with the frame pulse swaps immediately instead of waiting a frame.
    assign w_swap  = bus.frame_start && (r_pending || bus.commit);
    assign w_wr_ok = bus.wr_en && !r_pending && ({1'b0, bus.wr_idx} < IDX_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending   <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_swap) begin
                r_pending <= 1'b0;
            end else if (bus.commit) begin
                r_pending <= 1'b1;
            end
            if (bus.wr_en && r_pending) begin
                r_overrun <= 1'b1;
            end
            if (bus.frame_start) begin
                r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
            end
        end
    end

    for (genvar i = 0; i < N_SPRITES; i++) begin : g_sprite
        logic [X_W-1:0]   r_back_x;
        logic [Y_W-1:0]   r_back_y;
        logic [DIR_W-1:0] r_back_dir;
        logic [X_W-1:0]   r_front_x;
        logic [Y_W-1:0]   r_front_y;
        logic [DIR_W-1:0] r_front_dir;

        // NOTE: entries are plain registers rather than RAM, so each one is reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_back_x    <= '0;
                r_back_y    <= '0;
                r_back_dir  <= '0;
                r_front_x   <= '0;
                r_front_y   <= '0;
                r_front_dir <= '0;
            end else begin
                if (w_swap) begin
                    r_front_x   <= r_back_x;
                    r_front_y   <= r_back_y;
                    r_front_dir <= r_back_dir;
                end
                if (w_wr_ok && (bus.wr_idx == IDX_W'(i))) begin
                    r_back_x   <= bus.wr_x;
                    r_back_y   <= bus.wr_y;
                    r_back_dir <= bus.wr_dir;
                end
            end
        end

        assign o_front_x[i*X_W +: X_W]       = r_front_x;
        assign o_front_y[i*Y_W +: Y_W]       = r_front_y;
        assign o_front_dir[i*DIR_W +: DIR_W] = r_front_dir;
    end

    frame_tick_div #(
        .FRAMES_PER_TICK(FRAMES_PER_TICK)
    ) u_tick_div (
        .clk          (clk),
        .rst          (rst),
        .i_frame_start(bus.frame_start),
        .i_pause      (bus.pause),
        .o_tick       (w_tick)
    );

    assign bus.tick    = w_tick;
    assign bus.pending = r_pending;
    assign bus.overrun = r_overrun;
    assign o_frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_sprite_frame_buffer.sv
// Self-checking bench for sprite_frame_buffer: directed scenarios plus randomized traffic
// compared against a behavioural model of the double buffer and tick divider.
module tb_sprite_frame_buffer;
    import game_pkg::*;

    localparam int N   = 5;
    localparam int XW  = 11;
    localparam int YW  = 10;
    localparam int DW  = 4;
    localparam int FPT = 4;
    localparam int FW  = 16;
    localparam int IW  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sprite_frame_buffer_if #(.IDX_W(IW), .X_W(XW), .Y_W(YW), .DIR_W(DW)) bus ();

    logic [FW-1:0]   frame_cnt;
    logic [N*XW-1:0] front_x;
    logic [N*YW-1:0] front_y;
    logic [N*DW-1:0] front_dir;

    sprite_frame_buffer #(
        .N_SPRITES(N), .X_W(XW), .Y_W(YW), .DIR_W(DW),
        .FRAMES_PER_TICK(FPT), .FRAME_W(FW), .IDX_W(IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_frame_cnt(frame_cnt),
        .o_front_x  (front_x),
        .o_front_y  (front_y),
        .o_front_dir(front_dir)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [XW-1:0] m_back_x[N], m_front_x[N];
    logic [YW-1:0] m_back_y[N], m_front_y[N];
    logic [DW-1:0] m_back_d[N], m_front_d[N];
    bit            m_pending, m_overrun, m_tick;
    logic [FW-1:0] m_fcnt;
    int            m_div;

    function automatic logic [XW-1:0] dut_x(input int i);
        return front_x[i*XW +: XW];
    endfunction
    function automatic logic [YW-1:0] dut_y(input int i);
        return front_y[i*YW +: YW];
    endfunction
    function automatic logic [DW-1:0] dut_d(input int i);
        return front_dir[i*DW +: DW];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_back_x[i] = '0; m_back_y[i] = '0; m_back_d[i] = '0;
            m_front_x[i] = '0; m_front_y[i] = '0; m_front_d[i] = '0;
        end
        m_pending = 0; m_overrun = 0; m_tick = 0; m_fcnt = '0; m_div = 0;
    endtask

    // Applies the buffer rules for one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit swap;
        bit wr_ok;
        swap  = bus.frame_start && (m_pending || bus.commit);
        wr_ok = bus.wr_en && !m_pending && (int'(bus.wr_idx) < N);
        if (bus.wr_en && m_pending) m_overrun = 1;
        if (swap) begin
            for (int i = 0; i < N; i++) begin
                m_front_x[i] = m_back_x[i];
                m_front_y[i] = m_back_y[i];
                m_front_d[i] = m_back_d[i];
            end
        end
        if (wr_ok) begin
            m_back_x[int'(bus.wr_idx)] = bus.wr_x;
            m_back_y[int'(bus.wr_idx)] = bus.wr_y;
            m_back_d[int'(bus.wr_idx)] = bus.wr_dir;
        end
        if (swap) m_pending = 0;
        else if (bus.commit) m_pending = 1;
        m_tick = 0;
        if (bus.frame_start) begin
            m_fcnt = m_fcnt + FW'(1);
            if (!bus.pause) begin
                m_div = m_div + 1;
                if (m_div == FPT) begin
                    m_div  = 0;
                    m_tick = 1;
                end
            end
        end
    endtask

    // One clock: model follows the edge, outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        bus.wr_en       = 1'b0;
        bus.commit      = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b expected 0", bus.pending); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
        n_checks++; if (bus.tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", bus.tick); end
        n_checks++; if (frame_cnt !== '0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        n_checks++; if (front_x !== '0 || front_y !== '0 || front_dir !== '0) begin
            n_fail++; $display("FAIL reset_front: got x=%h y=%h dir=%h expected all 0", front_x, front_y, front_dir);
        end
        // A pending commit is lost when reset hits mid-frame, and the back write with it.
        bus.wr_en = 1'b1; bus.wr_idx = 3'(PACMAN); bus.wr_x = 11'd5; bus.wr_y = 10'd6; bus.wr_dir = DIR_UP;
        step();
        bus.commit = 1'b1;
        step();
        n_checks++; if (bus.pending !== 1'b1) begin n_fail++; $display("FAIL pending_set: got %b expected 1", bus.pending); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL async_reset_pending: got %b expected 0", bus.pending); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.frame_start = 1'b1;
        step();
        n_checks++; if (dut_x(PACMAN) !== 11'd0 || bus.pending !== 1'b0) begin
            n_fail++; $display("FAIL reset_drops_commit: got x0=%0d pending=%b expected x0=0 pending=0", dut_x(PACMAN), bus.pending);
        end
        step();
    endtask

    task automatic test_basic_write();
        bus.wr_en = 1'b1; bus.wr_idx = 3'(PINKY); bus.wr_x = 11'd100; bus.wr_y = 10'd50; bus.wr_dir = DIR_LEFT;
        step();
        n_checks++; if (dut_x(PINKY) !== 11'd0) begin n_fail++; $display("FAIL write_not_visible: got x2=%0d expected 0", dut_x(PINKY)); end
        bus.commit = 1'b1;
        step();
        step();
        bus.frame_start = 1'b1;
        step();
        n_checks++; if (dut_x(PINKY) !== 11'd100 || dut_y(PINKY) !== 10'd50 || dut_d(PINKY) !== 4'b0100) begin
            n_fail++; $display("FAIL basic_swap: got x=%0d y=%0d dir=%b expected x=100 y=50 dir=0100", dut_x(PINKY), dut_y(PINKY), dut_d(PINKY));
        end
        n_checks++; if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL basic_pending_clear: got %b expected 0", bus.pending); end
        step();
    endtask

    task automatic test_bad_index();
        logic [N*XW-1:0] old_x;
        old_x = front_x;
        for (int k = N; k < 8; k++) begin
            bus.wr_en = 1'b1; bus.wr_idx = 3'(k); bus.wr_x = 11'h7ff; bus.wr_y = 10'h3ff; bus.wr_dir = DIR_RIGHT;
            step();
        end
        bus.commit = 1'b1;
        step();
        bus.frame_start = 1'b1;
        step();
        n_checks++; if (front_x !== old_x) begin n_fail++; $display("FAIL bad_index_front: got %h expected %h", front_x, old_x); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL bad_index_overrun: got %b expected 0", bus.overrun); end
        step();
    endtask

    task automatic test_overrun();
        logic [XW-1:0] old_x1;
        old_x1 = m_front_x[BLINKY];
        bus.commit = 1'b1;
        step();
        bus.wr_en = 1'b1; bus.wr_idx = 3'(BLINKY); bus.wr_x = 11'd7; bus.wr_y = 10'd1; bus.wr_dir = DIR_DOWN;
        step();
        n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b expected 1", bus.overrun); end
        bus.frame_start = 1'b1;
        step();
        n_checks++; if (dut_x(BLINKY) !== old_x1) begin n_fail++; $display("FAIL overrun_dropped: got x1=%0d expected %0d", dut_x(BLINKY), old_x1); end
        repeat (3) step();
        n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b expected 1", bus.overrun); end
    endtask

    task automatic test_coincident();
        logic [XW-1:0] old_x0;
        old_x0 = m_front_x[PACMAN];
        bus.commit = 1'b1; bus.frame_start = 1'b1;
        bus.wr_en = 1'b1; bus.wr_idx = 3'(PACMAN); bus.wr_x = 11'd9; bus.wr_y = m_back_y[PACMAN]; bus.wr_dir = m_back_d[PACMAN];
        step();
        n_checks++; if (dut_x(PACMAN) !== old_x0 || bus.pending !== 1'b0) begin
            n_fail++; $display("FAIL coincident_swap: got x0=%0d pending=%b expected x0=%0d pending=0", dut_x(PACMAN), bus.pending, old_x0);
        end
        n_checks++; if (dut_x(PINKY) !== 11'd100) begin n_fail++; $display("FAIL back_persists: got x2=%0d expected 100", dut_x(PINKY)); end
        step();
        bus.commit = 1'b1; bus.frame_start = 1'b1;
        step();
        n_checks++; if (dut_x(PACMAN) !== 11'd9) begin n_fail++; $display("FAIL coincident_next: got x0=%0d expected 9", dut_x(PACMAN)); end
        step();
    endtask

    task automatic test_tick();
        int ticks;
        ticks = 0;
        do_reset();
        for (int f = 1; f <= 10; f++) begin
            bus.pause = (f == 5 || f == 6);
            bus.frame_start = 1'b1;
            step();
            if (bus.tick === 1'b1) ticks++;
            n_checks++; if (bus.tick !== ((f == 4 || f == 10) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL tick_after_frame_%0d: got %b expected %b", f, bus.tick, (f == 4 || f == 10));
            end
            step();
            if (bus.tick === 1'b1) ticks++;
            n_checks++; if (bus.tick !== 1'b0) begin n_fail++; $display("FAIL tick_width_frame_%0d: got %b expected 0", f, bus.tick); end
        end
        bus.pause = 1'b0;
        n_checks++; if (ticks != 2) begin n_fail++; $display("FAIL tick_count: got %0d expected 2", ticks); end
        n_checks++; if (frame_cnt !== 16'd10) begin n_fail++; $display("FAIL tick_frame_cnt: got %0d expected 10", frame_cnt); end
    endtask

    task automatic test_random();
        int gap;
        for (int round = 0; round < 2; round++) begin
            do_reset();
            gap = 2;
            for (int c = 0; c < 250; c++) begin
                bus.pause       = ($urandom_range(0, 4) == 0);
                bus.frame_start = (gap >= 2) && ($urandom_range(0, 3) == 0);
                bus.wr_en       = $urandom_range(0, 1) == 1;
                bus.wr_idx      = 3'($urandom_range(0, 7));
                bus.wr_x        = 11'($urandom);
                bus.wr_y        = 10'($urandom);
                bus.wr_dir      = 4'($urandom);
                bus.commit      = ($urandom_range(0, 5) == 0);
                gap = bus.frame_start ? 1 : gap + 1;
                step();
                n_checks++; if (bus.pending !== m_pending || bus.overrun !== m_overrun || bus.tick !== m_tick) begin
                    n_fail++; $display("FAIL rand_status c=%0d: got p=%b o=%b t=%b expected p=%b o=%b t=%b",
                        c, bus.pending, bus.overrun, bus.tick, m_pending, m_overrun, m_tick);
                end
                n_checks++; if (frame_cnt !== m_fcnt) begin n_fail++; $display("FAIL rand_frame_cnt c=%0d: got %0d expected %0d", c, frame_cnt, m_fcnt); end
                for (int i = 0; i < N; i++) begin
                    n_checks++; if (dut_x(i) !== m_front_x[i] || dut_y(i) !== m_front_y[i] || dut_d(i) !== m_front_d[i]) begin
                        n_fail++; $display("FAIL rand_front c=%0d i=%0d: got %0d/%0d/%b expected %0d/%0d/%b",
                            c, i, dut_x(i), dut_y(i), dut_d(i), m_front_x[i], m_front_y[i], m_front_d[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        bus.frame_start = 1'b0; bus.pause = 1'b0; bus.wr_en = 1'b0; bus.wr_idx = '0;
        bus.wr_x = '0; bus.wr_y = '0; bus.wr_dir = '0; bus.commit = 1'b0;
        model_reset();
        test_reset();
        test_basic_write();
        test_bad_index();
        test_overrun();
        test_coincident();
        test_tick();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
